pipe_alu_hs: RTL and testbench

//  Parametrised, 2-stage pipelined successor to the 8-bit combinational simple ALU.

---
 rtl/pipe_alu_hs.sv | 181 ++++++++++++++++++
 tb/tb_pipe_alu_hs.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_hs.sv
// pipe_alu_hs: two-stage pipelined ALU with valid/ready handshakes on both
// sides and an internal accumulator that can stand in for operand B.
//
// Ports
//   clk          clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   in_valid_i   operand beat valid
//   in_ready_o   block can accept an operand beat
//   a_i, b_i     operands (b_i ignored when acc_sel_i=1)
//   op_i         0 ADD, 1 SUB, 2 SLL, 3 LSR, 4 AND, 5 OR, 6 XOR, 7 EQL
//   acc_sel_i    use accumulator as operand B
//   acc_clr_i    synchronous accumulator clear
//   out_valid_o  result beat valid
//   out_ready_i  consumer accepts result beat
//   alu_o        result
//   zero_o       result == 0
//   neg_o        result MSB
//   carry_o      ADD carry-out / SUB borrow, 0 for other ops
//   ovf_o        signed overflow for ADD/SUB, 0 for other ops
module pipe_alu_hs #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic             acc_sel_i,
    input  logic             acc_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SLL = 3'd2,
        OP_LSR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_EQL = 3'd7
    } op_e;

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    op_e              s1_op_q;
    logic             s1_acc_sel_q;

    // Stage 2 registers
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_res_q;
    logic             s2_zero_q;
    logic             s2_neg_q;
    logic             s2_carry_q;
    logic             s2_ovf_q;

    logic [WIDTH-1:0] acc_q;

    // Handshake
    logic s2_free;
    logic s1_move;
    logic in_fire;

    assign s2_free    = !s2_valid_q || out_ready_i;
    assign s1_move    = s1_valid_q && s2_free;
    assign in_ready_o = !s1_valid_q || s1_move;
    assign in_fire    = in_valid_i && in_ready_o;

    // Stage 2 combinational compute
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;

    // The accumulator always holds the previous beat's result, so reading it
    // here (at compute time) gives back-to-back accumulation with no hazard.
    assign op_b   = s1_acc_sel_q ? acc_q : s1_b_q;
    assign sum_w  = {1'b0, s1_a_q} + {1'b0, op_b};
    assign diff_w = {1'b0, s1_a_q} - {1'b0, op_b};
    assign shamt  = op_b[SHW-1:0];

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_d   = sum_w[WIDTH-1:0];
                carry_d = sum_w[WIDTH];
                ovf_d   = (s1_a_q[WIDTH-1] == op_b[WIDTH-1]) &&
                          (res_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = diff_w[WIDTH-1:0];
                carry_d = diff_w[WIDTH];
                ovf_d   = (s1_a_q[WIDTH-1] != op_b[WIDTH-1]) &&
                          (res_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SLL: res_d = s1_a_q << shamt;
            OP_LSR: res_d = s1_a_q >> shamt;
            OP_AND: res_d = s1_a_q & op_b;
            OP_OR:  res_d = s1_a_q | op_b;
            OP_XOR: res_d = s1_a_q ^ op_b;
            OP_EQL: res_d[0] = (s1_a_q == op_b);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= OP_ADD;
            s1_acc_sel_q <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q   <= 1'b1;
            s1_a_q       <= a_i;
            s1_b_q       <= b_i;
            s1_op_q      <= op_e'(op_i);
            s1_acc_sel_q <= acc_sel_i;
        end else if (s1_move) begin
            s1_valid_q   <= 1'b0;
        end
    end

    // Flags are registered rather than decoded from alu_o so that reset can
    // hold every flag at 0 even though the reset result is 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_carry_q <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else if (s1_move) begin
            s2_valid_q <= 1'b1;
            s2_res_q   <= res_d;
            s2_zero_q  <= (res_d == '0);
            s2_neg_q   <= res_d[WIDTH-1];
            s2_carry_q <= carry_d;
            s2_ovf_q   <= ovf_d;
        end else if (out_ready_i) begin
            s2_valid_q <= 1'b0;
        end
    end

    // A result produced on the same edge as a clear takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (s1_move) begin
            acc_q <= res_d;
        end else if (acc_clr_i) begin
            acc_q <= '0;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign alu_o       = s2_res_q;
    assign zero_o      = s2_zero_q;
    assign neg_o       = s2_neg_q;
    assign carry_o     = s2_carry_q;
    assign ovf_o       = s2_ovf_q;

endmodule

// File: tb/tb_pipe_alu_hs.sv
// tb_pipe_alu_hs: directed-vector bench for pipe_alu_hs (WIDTH=8) with a
// transaction-level model and per-beat literal expectations.
module tb_pipe_alu_hs;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [2:0]   op_i;
    logic         acc_sel_i;
    logic         acc_clr_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] alu_o;
    logic         zero_o;
    logic         neg_o;
    logic         carry_o;
    logic         ovf_o;

    always #5 clk = ~clk;

    pipe_alu_hs #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .acc_sel_i   (acc_sel_i),
        .acc_clr_i   (acc_clr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .alu_o       (alu_o),
        .zero_o      (zero_o),
        .neg_o       (neg_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o)
    );

    logic [3:0] flags;
    assign flags = {zero_o, neg_o, carry_o, ovf_o};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] alu;
        logic [3:0] flags;
        logic [7:0] lit_alu;
        logic [3:0] lit_flags;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] model_acc = '0;
    logic [7:0] lit_alu   = '0;
    logic [3:0] lit_flags = '0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_alu;
    logic [3:0] prev_flags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic reference for one operation; flags = {zero,neg,carry,ovf}.
    function automatic void model_alu(input logic [7:0] a, input logic [7:0] b,
                                      input logic [2:0] op,
                                      output logic [7:0] r, output logic [3:0] f);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int t;
        int s;
        bit c = 1'b0;
        bit o = 1'b0;
        case (op)
            3'd0: begin t = ua + ub; r = t[7:0]; c = (t > 255);
                        s = sa + sb; o = (s > 127) || (s < -128); end
            3'd1: begin t = ua - ub; r = t[7:0]; c = (ua < ub);
                        s = sa - sb; o = (s > 127) || (s < -128); end
            3'd2: r = a << (ub % 8);
            3'd3: r = a >> (ub % 8);
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        f = {(r == 8'd0), r[7], c, o};
    endfunction

    // Compare process: sampled on the falling edge, between active edges.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            model_acc  = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
                chk("hold_alu", {24'd0, alu_o}, {24'd0, prev_alu});
                chk("hold_flags", {28'd0, flags}, {28'd0, prev_flags});
            end
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_result: got 0x%0h expected no beat", alu_o);
                end else begin
                    e = q.pop_front();
                    chk("model_alu", {24'd0, alu_o}, {24'd0, e.alu});
                    chk("model_flags", {28'd0, flags}, {28'd0, e.flags});
                    chk("lit_alu", {24'd0, alu_o}, {24'd0, e.lit_alu});
                    chk("lit_flags", {28'd0, flags}, {28'd0, e.lit_flags});
                end
            end
            // Clears are only issued while nothing is in flight.
            if (acc_clr_i) model_acc = '0;
            if (in_valid_i && in_ready_o) begin
                model_alu(a_i, acc_sel_i ? model_acc : b_i, op_i, e.alu, e.flags);
                e.lit_alu   = lit_alu;
                e.lit_flags = lit_flags;
                q.push_back(e);
                model_acc = e.alu;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_alu   = alu_o;
            prev_flags = flags;
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic sel, input logic [7:0] la, input logic [3:0] lf);
        a_i       = a;
        b_i       = b;
        op_i      = op;
        acc_sel_i = sel;
        lit_alu   = la;
        lit_flags = lf;
    endtask

    // Entered and left just after a rising edge; back-to-back calls give 1 beat/clk.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic sel, input logic [7:0] la, input logic [3:0] lf);
        bit done = 1'b0;
        drive(a, b, op, sel, la, lf);
        in_valid_i = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready_o=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid_o) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        op_i        = '0;
        acc_sel_i   = 1'b0;
        acc_clr_i   = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_alu", {24'd0, alu_o}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Arithmetic/flag vectors; first one also pins the two-edge latency.
        send(8'hF0, 8'h20, 3'd0, 1'b0, 8'h10, 4'b0010);
        chk("lat_s1_valid", {31'd0, out_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_s2_valid", {31'd0, out_valid_o}, 32'd1);
        chk("lat_s2_alu", {24'd0, alu_o}, 32'h10);
        send(8'h7F, 8'hFF, 3'd1, 1'b0, 8'h80, 4'b0111);
        send(8'h81, 8'h09, 3'd2, 1'b0, 8'h02, 4'b0000);
        send(8'h3C, 8'h3C, 3'd7, 1'b0, 8'h01, 4'b0000);
        send(8'h3C, 8'h3D, 3'd7, 1'b0, 8'h00, 4'b1000);
        send(8'h80, 8'h0F, 3'd3, 1'b0, 8'h01, 4'b0000);
        send(8'h7F, 8'h01, 3'd0, 1'b0, 8'h80, 4'b0101);
        send(8'h05, 8'h05, 3'd1, 1'b0, 8'h00, 4'b1000);
        send(8'h00, 8'h01, 3'd1, 1'b0, 8'hFF, 4'b0110);
        send(8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 4'b1010);
        send(8'hF0, 8'h3C, 3'd4, 1'b0, 8'h30, 4'b0000);
        wait_drain();

        // Accumulator chain, then clear with no beat in flight.
        send(8'h05, 8'h00, 3'd0, 1'b0, 8'h05, 4'b0000);
        send(8'h03, 8'hAA, 3'd0, 1'b1, 8'h08, 4'b0000);
        send(8'h03, 8'hAA, 3'd0, 1'b1, 8'h0B, 4'b0000);
        wait_drain();
        acc_clr_i = 1'b1;
        @(posedge clk);
        #1 acc_clr_i = 1'b0;
        send(8'h03, 8'hAA, 3'd0, 1'b1, 8'h03, 4'b0000);
        wait_drain();

        // Backpressure: two beats fill the pipe, the third must wait.
        out_ready_i = 1'b0;
        send(8'h11, 8'h22, 3'd0, 1'b0, 8'h33, 4'b0000);
        send(8'h40, 8'h01, 3'd2, 1'b0, 8'h80, 4'b0100);
        drive(8'h0F, 8'hF0, 3'd5, 1'b0, 8'hFF, 4'b0100);
        in_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
            chk("bp_alu", {24'd0, alu_o}, 32'h33);
        end
        @(posedge clk);
        #1 out_ready_i = 1'b1;
        send(8'h0F, 8'hF0, 3'd5, 1'b0, 8'hFF, 4'b0100);
        send(8'hAA, 8'hFF, 3'd6, 1'b0, 8'h55, 4'b0000);
        wait_drain();

        // Reset with both stages full: in-flight beats vanish, acc returns to 0.
        out_ready_i = 1'b0;
        send(8'h01, 8'h02, 3'd0, 1'b0, 8'h03, 4'b0000);
        send(8'h10, 8'h20, 3'd0, 1'b0, 8'h30, 4'b0000);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_alu", {24'd0, alu_o}, 32'd0);
        chk("mid_rst_flags", {28'd0, flags}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n     = 1'b1;
        out_ready_i = 1'b1;
        send(8'h03, 8'h77, 3'd0, 1'b1, 8'h03, 4'b0000);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
